// File: rtl/matrix_pkg.sv
// Shared constants, element type and FSM state type for the matrix divider.
package matrix_pkg;
  localparam int W      = 8;
  localparam int N_ELEM = 25;
  localparam int MAT_W  = N_ELEM * W;
  localparam int IW     = $clog2(N_ELEM);
  localparam int CW     = $clog2(W + 1);

  typedef logic signed [W-1:0] elem_t;

  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_s8_seq.sv
// Sequential signed restoring divider: load magnitudes, W shift/subtract steps, signed quotient.
// MATRIX_DIV_SAT_EN selects saturation (+127) instead of wrap for -128 / -1.
module div_s8_seq
  import matrix_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  elem_t a,
  input  elem_t b,
  output elem_t q,
  output logic  q_valid
);
  logic [W:0]    a_ext, b_ext, a_mag, b_mag;
  logic [W:0]    bm_q, bm_d;
  logic [W-1:0]  dq_q, dq_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qmsb_q, qmsb_d;
  logic          neg_q, neg_d;
  logic          act_q, act_d;
  logic [W:0]    rem_sh;
  logic          ge;
  logic [W:0]    qmag;
  logic [W-1:0]  qsgn;

  always_comb begin
    a_ext  = {a[W-1], a};
    b_ext  = {b[W-1], b};
    a_mag  = a[W-1] ? (~a_ext + 1'b1) : a_ext;
    b_mag  = b[W-1] ? (~b_ext + 1'b1) : b_ext;
    rem_sh = {rem_q, dq_q[W-1]};
    ge     = (rem_sh >= bm_q);

    bm_d   = bm_q;
    dq_d   = dq_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    qmsb_d = qmsb_q;
    neg_d  = neg_q;
    act_d  = act_q;

    if (load) begin
      // Only |a|=128 sets bit W; resolving that quotient bit here keeps the loop at W steps.
      qmsb_d = a_mag[W] && (b_mag == (W+1)'(1));
      rem_d  = (a_mag[W] && !qmsb_d) ? W'(1) : '0;
      dq_d   = a_mag[W-1:0];
      bm_d   = b_mag;
      neg_d  = a[W-1] ^ b[W-1];
      cnt_d  = CW'(W);
      act_d  = 1'b1;
    end else if (cnt_q != '0) begin
      rem_d = W'(ge ? (rem_sh - bm_q) : rem_sh);
      dq_d  = {dq_q[W-2:0], ge};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    qmag    = {qmsb_q, dq_q};
    qsgn    = W'(neg_q ? (~qmag + 1'b1) : qmag);
`ifdef MATRIX_DIV_SAT_EN
    q       = (!neg_q && qmag[W]) ? elem_t'({1'b0, {(W-1){1'b1}}}) : elem_t'(qsgn);
`else
    q       = elem_t'(qsgn);
`endif
    q_valid = act_q && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bm_q   <= '0;
      dq_q   <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      qmsb_q <= 1'b0;
      neg_q  <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      bm_q   <= bm_d;
      dq_q   <= dq_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      qmsb_q <= qmsb_d;
      neg_q  <= neg_d;
      act_q  <= act_d;
    end
  end
endmodule

// File: rtl/divisao_num_matriz.sv
// Divides each element of a packed 5x5 signed matrix by one signed integer, one element at a time.
// MATRIX_DIV_SAT_EN (in div_s8_seq) selects saturation for -128 / -1.
module divisao_num_matriz
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAT_W-1:0] matriz_A,
  input  elem_t            num_inteiro,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [MAT_W-1:0] nova_matriz_A
);
  div_state_t       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    it_q, it_d;
  logic [MAT_W-1:0] a_q, a_d;
  elem_t            b_q, b_d;
  logic [MAT_W-1:0] res_q, res_d;
  logic [MAT_W-1:0] nova_q, nova_d;
  logic             dz_q, dz_d;
  logic             load;
  elem_t            q;
  logic             q_valid;

  div_s8_seq u_div (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .a       (elem_t'(a_q[idx_q*W +: W])),
    .b       (b_q),
    .q       (q),
    .q_valid (q_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_inteiro == '0) ? DONE : SETUP;
      SETUP:   state_d = ITER;
      ITER:    if (it_q == CW'(W-1)) state_d = FIX;
      FIX:     state_d = (idx_q == IW'(N_ELEM-1)) ? DONE : SETUP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SETUP) || (state_q == ITER) || (state_q == FIX);
    done = (state_q == DONE);
    load = (state_q == SETUP);
  end

  always_comb begin
    idx_d  = idx_q;
    it_d   = it_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    nova_d = nova_q;
    dz_d   = dz_q;
    case (state_q)
      IDLE: if (start) begin
        a_d   = matriz_A;
        b_d   = num_inteiro;
        idx_d = '0;
        res_d = '0;
        dz_d  = (num_inteiro == '0);
        if (num_inteiro == '0) nova_d = '0;
      end
      SETUP: it_d = '0;
      ITER:  it_d = it_q + 1'b1;
      FIX: begin
        if (q_valid) res_d[idx_q*W +: W] = q;
        // Last slot is forwarded straight to the output so it is valid in the DONE cycle.
        if (idx_q == IW'(N_ELEM-1)) nova_d = res_d;
        else                        idx_d  = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      it_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      nova_q <= '0;
      dz_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      it_q   <= it_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      nova_q <= nova_d;
      dz_q   <= dz_d;
    end
  end

  assign div_zero      = dz_q;
  assign nova_matriz_A = nova_q;
endmodule

// File: tb/tb_divisao_num_matriz.sv
// Self-checking bench for divisao_num_matriz against an element-wise '/' reference model.
module tb_divisao_num_matriz;
  import matrix_pkg::*;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [MAT_W-1:0] matriz_A, nova_matriz_A;
  elem_t            num_inteiro;
  logic             busy, done, div_zero;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  divisao_num_matriz dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .matriz_A      (matriz_A),
    .num_inteiro   (num_inteiro),
    .busy          (busy),
    .done          (done),
    .div_zero      (div_zero),
    .nova_matriz_A (nova_matriz_A)
  );

  function automatic elem_t ref_q(elem_t a, elem_t b);
    int qi;
    if (b == 0) return '0;
    qi = int'(a) / int'(b);
    if (qi > 127) begin
`ifdef MATRIX_DIV_SAT_EN
      qi = 127;
`else
      qi = qi - 256;
`endif
    end
    return elem_t'(qi);
  endfunction

  function automatic logic [MAT_W-1:0] ref_mat(logic [MAT_W-1:0] m, elem_t b);
    logic [MAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_ELEM; i++) r[i*W +: W] = ref_q(elem_t'(m[i*W +: W]), b);
    return r;
  endfunction

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] m;
    for (int i = 0; i < N_ELEM; i++) m[i*W +: W] = W'($urandom);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string name, input logic [MAT_W-1:0] m, input elem_t d,
                         input int inj_cyc, input int rst_cyc);
    logic [MAT_W-1:0] got;
    int done_cnt, done_cyc;
    logic busy1;
    @(negedge clk);
    matriz_A = m; num_inteiro = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0; done_cyc = 0; got = '0; busy1 = busy;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          got = nova_matriz_A;
        end
      end
      if (cyc == rst_cyc + 1) begin
        rst = 1'b0;
        chk($sformatf("%s.rst_nova", name), nova_matriz_A, '0);
        chk($sformatf("%s.rst_flags", name), {busy, done, div_zero}, '0);
      end
      if (cyc == rst_cyc) rst = 1'b1;
      if (cyc == inj_cyc) begin
        start = 1'b1; matriz_A = rand_mat(); num_inteiro = elem_t'($urandom_range(1, 255));
      end
      if (cyc == inj_cyc + 1) start = 1'b0;
      @(posedge clk); #1;
    end
    if (rst_cyc > 0) begin
      chk($sformatf("%s.no_done", name), done_cnt, 0);
    end else begin
      chk($sformatf("%s.busy_c1", name), busy1, (d != 0));
      chk($sformatf("%s.done_cycle", name), done_cyc, (d == 0) ? 1 : 251);
      chk($sformatf("%s.done_count", name), done_cnt, 1);
      chk($sformatf("%s.result", name), got, ref_mat(m, d));
      chk($sformatf("%s.hold", name), nova_matriz_A, ref_mat(m, d));
      chk($sformatf("%s.div_zero", name), div_zero, (d == 0));
    end
  endtask

  initial begin
    logic [MAT_W-1:0] m;
    rst = 1'b1; start = 1'b0; matriz_A = '0; num_inteiro = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.nova", nova_matriz_A, '0);
    chk("reset.flags", {busy, done, div_zero}, '0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < N_ELEM; i++) m[i*W +: W] = 8'd20;
    run_job("t1_20div4", m, 8'sd4, -1, -1);

    for (int i = 0; i < N_ELEM; i++) m[i*W +: W] = (i % 2 == 0) ? -8'sd7 : 8'sd7;
    run_job("t2_trunc", m, 8'sd2, -1, -1);

    m = rand_mat();
    m[0 +: W] = 8'h80;
    m[W +: W] = 8'h80;
    run_job("t3_neg1", m, -8'sd1, -1, -1);
    run_job("t3_pos1", m, 8'sd1, -1, -1);

    run_job("t4_zero", rand_mat(), 8'sd0, -1, -1);
    run_job("t4_after0", rand_mat(), 8'sd3, -1, -1);

    run_job("t5_ignore", rand_mat(), elem_t'($urandom_range(1, 255)), 100, -1);

    run_job("t6_abort", rand_mat(), -8'sd5, -1, 120);
    run_job("t6_restart", rand_mat(), elem_t'($urandom_range(1, 255)), -1, -1);

    for (int k = 0; k < 3; k++)
      run_job($sformatf("rand%0d", k), rand_mat(), elem_t'($urandom_range(1, 255)), -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
